// File: rtl/alu_pkg.sv
// Shared ALU opcodes, RISC-V opcode constants and execute-stage types.
package alu_pkg;

  localparam int unsigned XLEN_W = 64;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    KIND_REG     = 2'd0,
    KIND_MEM     = 2'd1,
    KIND_BRANCH  = 2'd2,
    KIND_ILLEGAL = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [XLEN_W-1:0] a;
    logic [XLEN_W-1:0] b;
    kind_t             kind;
    logic [4:0]        rd;
    logic              we;
    logic              bne;
    logic [XLEN_W-1:0] bimm;
  } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one instruction slot into ALU drive and record fields.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [XLEN_W-1:0] rs1,
  input  logic [XLEN_W-1:0] rs2,
  output dec_t              dec_c
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN_W-1:0] imm_i;
  logic [XLEN_W-1:0] imm_s;
  logic              legal;
  logic              unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN_W-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN_W-12){instr[31]}}, instr[31:25], instr[11:7]};
  // Register specifiers are resolved upstream; only their data arrives here.
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    legal      = 1'b1;
    dec_c      = '0;
    dec_c.op   = OP_ADD;
    dec_c.a    = rs1;
    dec_c.b    = rs2;
    dec_c.kind = KIND_REG;
    case (opcode)
      OPC_R: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_c.op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_c.op = OP_SUB;
        else if (funct3 == 3'b111)                         dec_c.op = OP_AND;
        else if (funct3 == 3'b110)                         dec_c.op = OP_OR;
        else                                               legal = 1'b0;
      end
      OPC_I: begin
        dec_c.b = imm_i;
        case (funct3)
          3'b000:  dec_c.op = OP_ADD;
          3'b111:  dec_c.op = OP_AND;
          3'b110:  dec_c.op = OP_OR;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_c.b    = imm_i;
        dec_c.kind = KIND_MEM;
      end
      OPC_STORE: begin
        dec_c.b    = imm_s;
        dec_c.kind = KIND_MEM;
      end
      OPC_BRANCH: begin
        dec_c.op   = OP_SUB;
        dec_c.kind = KIND_BRANCH;
        if (funct3 != 3'b000 && funct3 != 3'b001) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // Illegal slots still drive a harmless ADD of zeros into the ALU.
    if (!legal) begin
      dec_c.op   = OP_ADD;
      dec_c.a    = '0;
      dec_c.b    = '0;
      dec_c.kind = KIND_ILLEGAL;
    end
    dec_c.rd   = (dec_c.kind == KIND_REG) ? instr[11:7] : 5'd0;
    dec_c.we   = (dec_c.kind == KIND_REG) && (instr[11:7] != 5'd0);
    dec_c.bne  = instr[12];
    dec_c.bimm = {{(XLEN_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage front end: registers ALU drive on acceptance, captures the
// ALU result one cycle later and holds a writeback/branch record until taken.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  output logic [XLEN-1:0] operand1_out,
  output logic [XLEN-1:0] operand2_out,
  output logic [2:0]      aluOpcode_out,
  input  logic [XLEN-1:0] aluResult_in,
  input  logic            aluZero_in,
  output logic            wb_valid_out,
  input  logic            wb_ready_in,
  output logic [1:0]      wb_kind_out,
  output logic [4:0]      wb_rd_out,
  output logic            wb_we_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out
);

  state_t          state;
  dec_t            dec_c;
  logic            accept_c;
  kind_t           kind_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic            bne_q;
  logic [XLEN-1:0] target_q;

  alu_decode u_decode (
    .instr (instr_in),
    .rs1   (rs1_data_in),
    .rs2   (rs2_data_in),
    .dec_c (dec_c)
  );

  // A finished record frees the slot in the same cycle the consumer takes it.
  assign instr_ready_out = (state == ST_IDLE) || ((state == ST_DONE) && wb_ready_in);
  assign accept_c        = instr_valid_in && instr_ready_out;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state             <= ST_IDLE;
      aluOpcode_out     <= OP_ADD;
      operand1_out      <= '0;
      operand2_out      <= '0;
      kind_q            <= KIND_REG;
      rd_q              <= '0;
      we_q              <= 1'b0;
      bne_q             <= 1'b0;
      target_q          <= '0;
      wb_valid_out      <= 1'b0;
      wb_kind_out       <= '0;
      wb_rd_out         <= '0;
      wb_we_out         <= 1'b0;
      wb_data_out       <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      if (accept_c) begin
        aluOpcode_out <= dec_c.op;
        operand1_out  <= dec_c.a;
        operand2_out  <= dec_c.b;
        kind_q        <= dec_c.kind;
        rd_q          <= dec_c.rd;
        we_q          <= dec_c.we;
        bne_q         <= dec_c.bne;
        target_q      <= (dec_c.kind == KIND_BRANCH) ? pc_in + dec_c.bimm : '0;
      end
      case (state)
        ST_IDLE: if (accept_c) state <= ST_EXEC;
        ST_EXEC: begin
          wb_valid_out      <= 1'b1;
          wb_kind_out       <= kind_q;
          wb_rd_out         <= rd_q;
          wb_we_out         <= we_q;
          wb_data_out       <= aluResult_in;
          branch_taken_out  <= (kind_q == KIND_BRANCH) && (aluZero_in ^ bne_q);
          branch_target_out <= target_q;
          state             <= ST_DONE;
        end
        ST_DONE: begin
          if (wb_ready_in) begin
            wb_valid_out <= 1'b0;
            state        <= accept_c ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an external ALU, a transaction-level
// reference model and a per-cycle compare process.
module tb_alu_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [31:0] instr_in;
  logic [63:0] pc_in;
  logic [63:0] rs1_data_in;
  logic [63:0] rs2_data_in;
  logic [63:0] operand1_out;
  logic [63:0] operand2_out;
  logic [2:0]  aluOpcode_out;
  logic [63:0] aluResult_in;
  logic        aluZero_in;
  logic        wb_valid_out;
  logic        wb_ready_in;
  logic [1:0]  wb_kind_out;
  logic [4:0]  wb_rd_out;
  logic        wb_we_out;
  logic [63:0] wb_data_out;
  logic        branch_taken_out;
  logic [63:0] branch_target_out;

  always #5 clk_in = ~clk_in;

  alu_sequencer dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .instr_valid_in    (instr_valid_in),
    .instr_ready_out   (instr_ready_out),
    .instr_in          (instr_in),
    .pc_in             (pc_in),
    .rs1_data_in       (rs1_data_in),
    .rs2_data_in       (rs2_data_in),
    .operand1_out      (operand1_out),
    .operand2_out      (operand2_out),
    .aluOpcode_out     (aluOpcode_out),
    .aluResult_in      (aluResult_in),
    .aluZero_in        (aluZero_in),
    .wb_valid_out      (wb_valid_out),
    .wb_ready_in       (wb_ready_in),
    .wb_kind_out       (wb_kind_out),
    .wb_rd_out         (wb_rd_out),
    .wb_we_out         (wb_we_out),
    .wb_data_out       (wb_data_out),
    .branch_taken_out  (branch_taken_out),
    .branch_target_out (branch_target_out)
  );

  // External combinational ALU.
  always_comb begin
    case (aluOpcode_out)
      3'b000:  aluResult_in = operand1_out & operand2_out;
      3'b001:  aluResult_in = operand1_out | operand2_out;
      3'b010:  aluResult_in = operand1_out + operand2_out;
      3'b110:  aluResult_in = operand1_out - operand2_out;
      default: aluResult_in = '0;
    endcase
  end
  assign aluZero_in = (aluResult_in == 64'd0);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic        taken;
    logic [63:0] target;
    int unsigned due;
  } exp_t;

  // Instruction semantics: what the record and ALU drive must be.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input logic [63:0] r1, input logic [63:0] r2);
    exp_t e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] ii;
    logic [63:0] si;
    logic [63:0] bi;
    logic        ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = 64'($signed(ins[31:20]));
    si = 64'($signed({ins[31:25], ins[11:7]}));
    bi = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    e.op = 3'b010; e.a = r1; e.b = r2; e.kind = 2'd0; e.rd = 5'd0; e.we = 1'b0;
    e.data = 64'd0; e.taken = 1'b0; e.target = 64'd0; e.due = 0;
    ok = 1'b1;
    case (ins[6:0])
      7'h33: begin
        if (f3 == 3'd0 && f7 == 7'h00)      begin e.op = 3'b010; e.data = r1 + r2; end
        else if (f3 == 3'd0 && f7 == 7'h20) begin e.op = 3'b110; e.data = r1 - r2; end
        else if (f3 == 3'd7)                begin e.op = 3'b000; e.data = r1 & r2; end
        else if (f3 == 3'd6)                begin e.op = 3'b001; e.data = r1 | r2; end
        else ok = 1'b0;
      end
      7'h13: begin
        e.b = ii;
        if (f3 == 3'd0)      begin e.op = 3'b010; e.data = r1 + ii; end
        else if (f3 == 3'd7) begin e.op = 3'b000; e.data = r1 & ii; end
        else if (f3 == 3'd6) begin e.op = 3'b001; e.data = r1 | ii; end
        else ok = 1'b0;
      end
      7'h03: begin e.kind = 2'd1; e.b = ii; e.data = r1 + ii; end
      7'h23: begin e.kind = 2'd1; e.b = si; e.data = r1 + si; end
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1) begin
          e.kind = 2'd2; e.op = 3'b110; e.data = r1 - r2;
          e.taken  = (f3 == 3'd0) ? (r1 == r2) : (r1 != r2);
          e.target = pc + bi;
        end else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.kind = 2'd3; e.op = 3'b010; e.a = 64'd0; e.b = 64'd0; e.data = 64'd0;
    end
    if (e.kind == 2'd0) begin
      e.rd = ins[11:7];
      e.we = (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  exp_t        q[$];
  exp_t        e_new;
  int unsigned cyc = 0;
  logic [2:0]  drv_op;
  logic [63:0] drv_a;
  logic [63:0] drv_b;
  logic        vis_m;
  logic        rdy_m;

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (reset_in) begin
      q.delete();
      drv_op = 3'b010; drv_a = 64'd0; drv_b = 64'd0;
    end else begin
      vis_m = (q.size() > 0) && (q[0].due <= cyc);
      rdy_m = (q.size() == 0) || (vis_m && wb_ready_in);
      chk("m_wb_valid", 64'(wb_valid_out), 64'(vis_m));
      chk("m_instr_ready", 64'(instr_ready_out), 64'(rdy_m));
      chk("m_alu_op", 64'(aluOpcode_out), 64'(drv_op));
      chk("m_operand1", operand1_out, drv_a);
      chk("m_operand2", operand2_out, drv_b);
      if (vis_m) begin
        chk("m_kind", 64'(wb_kind_out), 64'(q[0].kind));
        chk("m_rd", 64'(wb_rd_out), 64'(q[0].rd));
        chk("m_we", 64'(wb_we_out), 64'(q[0].we));
        chk("m_data", wb_data_out, q[0].data);
        chk("m_taken", 64'(branch_taken_out), 64'(q[0].taken));
        chk("m_target", branch_target_out, q[0].target);
        if (wb_ready_in) void'(q.pop_front());
      end
      if (instr_valid_in && rdy_m) begin
        e_new = model(instr_in, pc_in, rs1_data_in, rs2_data_in);
        e_new.due = cyc + 2;
        q.push_back(e_new);
        drv_op = e_new.op; drv_a = e_new.a; drv_b = e_new.b;
      end
    end
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {imm, 5'd1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  int lat;

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin @(negedge clk_in); n++; end while (!instr_ready_out && n < 20);
    if (!instr_ready_out) chk("accept_timeout", 64'(instr_ready_out), 64'd1);
  endtask

  // Present one instruction, then stop at the negedge where its record shows.
  task automatic send(input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] a, input logic [63:0] b);
    instr_in = ins; pc_in = pc; rs1_data_in = a; rs2_data_in = b;
    instr_valid_in = 1'b1;
    wait_accept();
    tick();
    instr_valid_in = 1'b0;
    lat = 0;
    do begin @(negedge clk_in); lat++; end while (!wb_valid_out && lat < 20);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ready"}, 64'(instr_ready_out), 64'd1);
    chk({tag, "_valid"}, 64'(wb_valid_out), 64'd0);
    chk({tag, "_op"}, 64'(aluOpcode_out), 64'd2);
    chk({tag, "_opnd1"}, operand1_out, 64'd0);
    chk({tag, "_opnd2"}, operand2_out, 64'd0);
    chk({tag, "_data"}, wb_data_out, 64'd0);
    chk({tag, "_kind"}, 64'(wb_kind_out), 64'd0);
    chk({tag, "_rd"}, 64'(wb_rd_out), 64'd0);
    chk({tag, "_we"}, 64'(wb_we_out), 64'd0);
    chk({tag, "_taken"}, 64'(branch_taken_out), 64'd0);
    chk({tag, "_target"}, branch_target_out, 64'd0);
  endtask

  logic [31:0] t_ins [0:8];
  logic [63:0] t_a   [0:8];
  logic [63:0] t_b   [0:8];

  initial begin
    reset_in = 1'b1; instr_valid_in = 1'b0; instr_in = '0; pc_in = '0;
    rs1_data_in = '0; rs2_data_in = '0; wb_ready_in = 1'b1;
    repeat (3) tick();
    reset_in = 1'b0;
    @(negedge clk_in);
    check_cleared("reset");
    tick();

    send(r_type(7'h00, 3'd0, 5'd3), 64'h0, 64'd5, 64'd7);
    chk("add_latency", 64'(lat), 64'd2);
    chk("add_op", 64'(aluOpcode_out), 64'd2);
    chk("add_data", wb_data_out, 64'd12);
    chk("add_rd", 64'(wb_rd_out), 64'd3);
    chk("add_we", 64'(wb_we_out), 64'd1);
    chk("add_kind", 64'(wb_kind_out), 64'd0);
    tick();

    send(r_type(7'h20, 3'd0, 5'd4), 64'h0, 64'd0, 64'd1);
    chk("sub_data", wb_data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    send(b_type(13'd16, 3'd0), 64'h1000, 64'h1234, 64'h1234);
    chk("beq_taken", 64'(branch_taken_out), 64'd1);
    chk("beq_target", branch_target_out, 64'h1010);
    chk("beq_we", 64'(wb_we_out), 64'd0);
    chk("beq_kind", 64'(wb_kind_out), 64'd2);
    tick();

    send(b_type(13'd16, 3'd1), 64'h1000, 64'h1234, 64'h1234);
    chk("bne_taken", 64'(branch_taken_out), 64'd0);
    chk("bne_target", branch_target_out, 64'h1010);
    tick();

    send(b_type(13'h1FFC, 3'd0), 64'h0, 64'd1, 64'd2);
    chk("beq_wrap_target", branch_target_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_wrap_taken", 64'(branch_taken_out), 64'd0);
    tick();

    send(i_type(12'hFFF, 3'd0, 5'd0, 7'h13), 64'h0, 64'd100, 64'd0);
    chk("addi_x0_we", 64'(wb_we_out), 64'd0);
    chk("addi_x0_data", wb_data_out, 64'd99);
    tick();

    send(32'h0000_007F, 64'h0, 64'd55, 64'd66);
    chk("illegal_kind", 64'(wb_kind_out), 64'd3);
    chk("illegal_taken", 64'(branch_taken_out), 64'd0);
    chk("illegal_data", wb_data_out, 64'd0);
    tick();

    t_ins = '{r_type(7'h00, 3'd7, 5'd8), r_type(7'h00, 3'd6, 5'd9),
              i_type(12'h0F0, 3'd7, 5'd10, 7'h13), i_type(12'h800, 3'd6, 5'd11, 7'h13),
              i_type(12'hFF8, 3'd2, 5'd12, 7'h03), s_type(12'd12, 3'd2),
              r_type(7'h01, 3'd0, 5'd13), i_type(12'h001, 3'd1, 5'd14, 7'h13),
              b_type(13'd8, 3'd4)};
    t_a = '{64'hF0F0, 64'hF0F0, 64'h0FF5, 64'h3, 64'h100, 64'h100, 64'd9, 64'd9, 64'd5};
    t_b = '{64'hFF00, 64'h0F0F, 64'h0, 64'h0, 64'h0, 64'h7, 64'd1, 64'd1, 64'd5};
    for (int i = 0; i < 9; i++) begin
      send(t_ins[i], 64'h40, t_a[i], t_b[i]);
      chk("table_latency", 64'(lat), 64'd2);
      tick();
    end

    // Consumer stalls for five cycles while a second instruction waits.
    wb_ready_in = 1'b0;
    instr_in = r_type(7'h00, 3'd0, 5'd5); rs1_data_in = 64'd40; rs2_data_in = 64'd2;
    instr_valid_in = 1'b1;
    wait_accept();
    tick();
    instr_in = r_type(7'h00, 3'd6, 5'd6); rs1_data_in = 64'hF0; rs2_data_in = 64'h0F;
    @(negedge clk_in);
    repeat (5) begin
      @(negedge clk_in);
      chk("stall_valid", 64'(wb_valid_out), 64'd1);
      chk("stall_ready", 64'(instr_ready_out), 64'd0);
      chk("stall_data", wb_data_out, 64'd42);
      chk("stall_rd", 64'(wb_rd_out), 64'd5);
    end
    tick();
    wb_ready_in = 1'b1;
    @(negedge clk_in);
    chk("release_ready", 64'(instr_ready_out), 64'd1);
    tick();
    instr_valid_in = 1'b0;
    @(negedge clk_in);
    chk("b2b_exec_valid", 64'(wb_valid_out), 64'd0);
    @(negedge clk_in);
    chk("b2b_valid", 64'(wb_valid_out), 64'd1);
    chk("b2b_data", wb_data_out, 64'hFF);
    chk("b2b_rd", 64'(wb_rd_out), 64'd6);
    tick();

    // Reset lands while an instruction is in EXEC.
    instr_in = b_type(13'd16, 3'd0); pc_in = 64'h2000;
    rs1_data_in = 64'd3; rs2_data_in = 64'd4;
    instr_valid_in = 1'b1;
    wait_accept();
    tick();
    instr_valid_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    @(negedge clk_in);
    check_cleared("exec_reset");
    repeat (4) begin
      @(negedge clk_in);
      chk("exec_reset_no_valid", 64'(wb_valid_out), 64'd0);
    end
    tick();

    send(r_type(7'h00, 3'd0, 5'd7), 64'h0, 64'd20, 64'd22);
    chk("recover_latency", 64'(lat), 64'd2);
    chk("recover_data", wb_data_out, 64'd42);
    tick();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execute-stage front end that drives the 64-bit ALU and consumes its result. It accepts one decoded-slot RISC-V instruction plus register operands over a valid/ready handshake and derives the ALU opcode and operands. It captures the ALU result and zero flag, then presents a writeback/branch record over a second valid/ready handshake. The block sits between the register-read stage and the ALU; the ALU instance itself is external and purely combinational.

## Interface
Parameters:
- XLEN, 64, datapath width (only 64 is supported)

Ports:
- clk_in  input  1  clock; single clock domain, all logic on rising edge
- reset_in  input  1  synchronous, active-high reset
- instr_valid_in  input  1  instruction slot valid
- instr_ready_out  output  1  block can accept instruction this cycle
- instr_in  input  32  raw instruction word
- pc_in  input  XLEN  instruction PC
- rs1_data_in / rs2_data_in  input  XLEN  register operands
- operand1_out / operand2_out  output  XLEN  to ALU operand1_in/operand2_in
- aluOpcode_out  output  3  to ALU aluOpcode_in
- aluResult_in  input  XLEN  from ALU result_out
- aluZero_in  input  1  from ALU zeroFlag_out
- wb_valid_out  output  1  record valid
- wb_ready_in  input  1  consumer accepts record
- wb_kind_out  output  2  KIND_REG / KIND_MEM / KIND_BRANCH / KIND_ILLEGAL
- wb_rd_out  output  5  destination register
- wb_we_out  output  1  register write enable
- wb_data_out  output  XLEN  ALU result (register value or memory address)
- branch_taken_out  output  1  branch resolved taken
- branch_target_out  output  XLEN  pc + sign-extended B-immediate

## Operation
- Decode by opcode[6:0]:
  - 0110011 R-type: funct3/funct7 000/0000000 -> OP_ADD, 000/0100000 -> OP_SUB, 111 -> OP_AND, 110 -> OP_OR. Operands are rs1, rs2. Kind is KIND_REG.
  - 0010011 I-type: funct3 000 ADDI, 111 ANDI, 110 ORI. Operands are rs1 and the sign-extended imm[31:20]. Kind is KIND_REG.
  - 0000011 load / 0100011 store: OP_ADD with rs1 plus the sign-extended I or S immediate. Kind is KIND_MEM. wb_we_out=0.
  - 1100011 branch: funct3 000 BEQ, 001 BNE. OP_SUB on rs1, rs2. Kind is KIND_BRANCH. BEQ is taken if aluZero_in; BNE is taken if !aluZero_in.
  - Anything else -> KIND_ILLEGAL. The ALU is still driven with OP_ADD on 0,0. wb_we_out=0. branch_taken_out=0.
- wb_we_out=1 only for KIND_REG with rd != 0.
- branch_taken_out=0 for all kinds other than KIND_BRANCH.
- The branch target uses a dedicated XLEN adder, not the ALU. Wrap-around is modulo 2^64.
- FSM with three states:
  - IDLE: instr_ready_out=1. On instr_valid_in, the decoded opcode and operands register into the ALU drive registers -> EXEC.
  - EXEC: the ALU settles. aluResult_in, aluZero_in, and the derived branch fields register into the output record -> DONE.
  - DONE: wb_valid_out=1, and the record is held stable until wb_ready_in.
    - On wb_ready_in with instr_valid_in, the next instruction is accepted directly -> EXEC. instr_ready_out equals wb_ready_in in DONE.
    - On wb_ready_in alone -> IDLE.
- ALU drive registers change only on instruction acceptance.

## Timing
- Reset: state IDLE. Every output is 0, except instr_ready_out=1 in the cycle after reset deasserts. aluOpcode_out resets to OP_ADD (value 3'b010).
- Reset mid-operation, in EXEC or DONE: the record in flight is discarded, with no wb_valid_out pulse.
- Latency: instruction accepted at edge N -> wb_valid_out high from edge N+2.
- Throughput: one instruction per 2 cycles when the consumer is always ready.
- Handshake rules:
  - A transfer occurs on the edge where valid && ready.
  - wb_valid_out never drops without wb_ready_in.
  - All wb_* fields stay stable while wb_valid_out && !wb_ready_in.
- No combinational path from wb_ready_in or instr_valid_in to ALU outputs. instr_ready_out is combinational from state and wb_ready_in only.

## Structure
- Shared package alu_pkg holds:
  - the OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110 constants, shared with the ALU;
  - a kind_t enum (KIND_REG=0, KIND_MEM=1, KIND_BRANCH=2, KIND_ILLEGAL=3);
  - RISC-V opcode constants;
  - a state_t enum.
- One sub-module, alu_decode: a purely combinational mapping of instr_in, rs1, rs2 to opcode, operands, kind, rd, and the branch immediate. The FSM and registers stay in alu_sequencer.

## Test plan
- Run reset, then ADD x3,x1,x2 with rs1=5, rs2=7 and wb_ready_in=1.
  - Required: aluOpcode_out=OP_ADD, wb_valid_out two edges after acceptance, wb_data_out=12, wb_rd_out=3, wb_we_out=1, kind REG.
- Run SUB with rs1=0, rs2=1.
  - Required: wb_data_out=64'hFFFF_FFFF_FFFF_FFFF.
- Run BEQ with rs1=rs2=0x1234, pc=0x1000, imm=+16.
  - Required: branch_taken_out=1, branch_target_out=0x1010, wb_we_out=0.
- Run BNE with the same operands.
  - Required: taken=0.
- Run ADDI x0,x1,-1 followed by opcode 0x7F.
  - Required: the first gives wb_we_out=0 with data=rs1-1; the second gives kind ILLEGAL with taken=0.
- Hold wb_ready_in=0 for 5 cycles with a second instruction pending.
  - Required: the record is stable and instr_ready_out=0.
  - Then raise wb_ready_in together with instr_valid_in: the new instruction is accepted that edge, and its record follows 2 edges later.
- Assert reset_in while in EXEC.
  - Required: next cycle all outputs are 0 except instr_ready_out=1, and no wb_valid_out occurs.
